// File: rtl/coin_acceptor.sv
// Coin acceptor front end: detects coins on the slot sensor, classifies them
// by size, buffers valid coins in a small FIFO and releases one per cycle to
// the vending controller while it asserts enable. Invalid coins, overflow
// coins and coins seen during a jam open the return gate for REJ_HOLD cycles.
//
// Handshake: the controller's enable acts as "ready". A coin is released
// (deposit != NONE for one cycle) at every edge where enable=1 and the FIFO
// held at least one coin before that edge. The coin producer (the sensor) has
// no back-pressure, so overflow becomes a reject.
module coin_acceptor #(
  parameter int DEPTH      = 4,
  parameter int SW         = 6,
  parameter int DIME_LO    = 17,
  parameter int DIME_HI    = 18,
  parameter int NICKEL_LO  = 20,
  parameter int NICKEL_HI  = 22,
  parameter int QUARTER_LO = 24,
  parameter int QUARTER_HI = 25,
  parameter int REJ_HOLD   = 3,
  parameter int JAM_CYCLES = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          sense_valid,
  input  logic [SW-1:0] sense_size,
  input  logic          enable,
  output logic [1:0]    deposit,
  output logic          reject,
  output logic          jam,
  output logic [2:0]    count
);

  localparam logic [1:0] COIN_NONE    = 2'd0;
  localparam logic [1:0] COIN_NICKEL  = 2'd1;
  localparam logic [1:0] COIN_DIME    = 2'd2;
  localparam logic [1:0] COIN_QUARTER = 2'd3;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = $clog2(REJ_HOLD + 1);
  localparam int HW = $clog2(JAM_CYCLES + 1);

  logic          sense_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic [1:0]    deposit_q, deposit_d;
  logic [RW-1:0] rej_cnt_q, rej_cnt_d;
  logic          reject_q, reject_d;
  logic [HW-1:0] hi_cnt_q, hi_cnt_d;
  logic          jam_q, jam_d;
  logic [1:0]    mem [DEPTH];

  logic [1:0]    coin_class;
  logic          coin_evt;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          rej_evt;

  // Size-window classification; NONE marks an invalid coin.
  always_comb begin
    coin_class = COIN_NONE;
    if (sense_size >= SW'(DIME_LO) && sense_size <= SW'(DIME_HI))
      coin_class = COIN_DIME;
    else if (sense_size >= SW'(NICKEL_LO) && sense_size <= SW'(NICKEL_HI))
      coin_class = COIN_NICKEL;
    else if (sense_size >= SW'(QUARTER_LO) && sense_size <= SW'(QUARTER_HI))
      coin_class = COIN_QUARTER;
  end

  // Next-state logic for FIFO, release register, reject timer and jam detector.
  always_comb begin
    coin_evt  = sense_valid & ~sense_q;
    fifo_full = (count_q == 3'(DEPTH));
    pop       = enable & (count_q != 3'd0);
    push      = coin_evt & ~jam_q & (coin_class != COIN_NONE) & (~fifo_full | pop);
    rej_evt   = coin_evt & (jam_q | (coin_class == COIN_NONE) | (fifo_full & ~pop));

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    deposit_d = COIN_NONE;

    if (push)
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop) begin
      deposit_d = mem[rd_ptr_q];
      rd_ptr_d  = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};

    // Every reject event restarts the full hold window.
    if (rej_evt)
      rej_cnt_d = RW'(REJ_HOLD);
    else if (rej_cnt_q != '0)
      rej_cnt_d = rej_cnt_q - 1'b1;
    else
      rej_cnt_d = rej_cnt_q;
    reject_d = (rej_cnt_d != '0);

    // Run length of sense_valid, saturating at the jam threshold.
    if (!sense_valid)
      hi_cnt_d = '0;
    else if (hi_cnt_q != HW'(JAM_CYCLES))
      hi_cnt_d = hi_cnt_q + 1'b1;
    else
      hi_cnt_d = hi_cnt_q;
    jam_d = jam_q | (hi_cnt_d == HW'(JAM_CYCLES));
  end

  // Control and output registers; reset discards buffered coins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sense_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 3'd0;
      deposit_q <= COIN_NONE;
      rej_cnt_q <= '0;
      reject_q  <= 1'b0;
      hi_cnt_q  <= '0;
      jam_q     <= 1'b0;
    end else begin
      sense_q   <= sense_valid;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      deposit_q <= deposit_d;
      rej_cnt_q <= rej_cnt_d;
      reject_q  <= reject_d;
      hi_cnt_q  <= hi_cnt_d;
      jam_q     <= jam_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr_q] <= coin_class;
  end

  assign deposit = deposit_q;
  assign reject  = reject_q;
  assign jam     = jam_q;
  assign count   = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus randomized coin traffic,
// checked every cycle against a queue-based behavioural model.
module tb_coin_acceptor;

  localparam int DEPTH    = 4;
  localparam int REJ_HOLD = 3;
  localparam int JAM      = 8;

  logic       clock;
  logic       reset_n;
  logic       sense_valid;
  logic [5:0] sense_size;
  logic       enable;
  logic [1:0] deposit;
  logic       reject;
  logic       jam;
  logic [2:0] count;

  coin_acceptor dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sense_valid (sense_valid),
    .sense_size  (sense_size),
    .enable      (enable),
    .deposit     (deposit),
    .reject      (reject),
    .jam         (jam),
    .count       (count)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [1:0] exp_q[$];
  logic [1:0] m_dep;
  int         m_cyc;
  int         m_last_rej;
  int         m_run;
  bit         m_jam;
  bit         m_prev;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] classify(input int s);
    if (s >= 17 && s <= 18) return 2'd2;
    if (s >= 20 && s <= 22) return 2'd1;
    if (s >= 24 && s <= 25) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_dep      = 2'd0;
    m_last_rej = -1000;
    m_run      = 0;
    m_jam      = 1'b0;
    m_prev     = 1'b0;
  endtask

  task automatic model_step(input bit sv, input int sz, input bit en);
    int         occ;
    bit         popped;
    logic [1:0] c;
    occ    = exp_q.size();
    popped = en && (occ > 0);
    m_dep  = popped ? exp_q.pop_front() : 2'd0;
    if (sv && !m_prev) begin
      c = classify(sz);
      if (m_jam || c == 2'd0 || (occ == DEPTH && !popped))
        m_last_rej = m_cyc;
      else
        exp_q.push_back(c);
    end
    m_run = sv ? ((m_run < JAM) ? m_run + 1 : JAM) : 0;
    if (m_run >= JAM) m_jam = 1'b1;
    m_prev = sv;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".deposit"}, int'(deposit), int'(m_dep));
    chk({tag, ".reject"},  int'(reject),  int'((m_cyc - m_last_rej) < REJ_HOLD));
    chk({tag, ".jam"},     int'(jam),     int'(m_jam));
    chk({tag, ".count"},   int'(count),   exp_q.size());
  endtask

  // Driver: apply one cycle of inputs, advance the model, check at negedge.
  task automatic step(input bit sv, input int sz, input bit en, input string tag);
    logic [31:0] szv;
    szv         = sz;
    sense_valid = sv;
    sense_size  = szv[5:0];
    enable      = en;
    @(posedge clock);
    m_cyc++;
    model_step(sv, sz, en);
    @(negedge clock);
    check_outputs(tag);
  endtask

  // One coin: sensor high for hi cycles (size glitches after the first), then low.
  // en_mode 0/1 fixes enable, 2 randomizes it per cycle.
  task automatic coin(input int sz, input int hi, input int gap, input int en_mode, input string tag);
    for (int i = 0; i < hi; i++)
      step(1'b1, (i == 0) ? sz : int'($urandom_range(0, 63)),
           (en_mode == 2) ? bit'($urandom_range(0, 1)) : bit'(en_mode), tag);
    for (int i = 0; i < gap; i++)
      step(1'b0, int'($urandom_range(0, 63)),
           (en_mode == 2) ? bit'($urandom_range(0, 1)) : bit'(en_mode), tag);
  endtask

  task automatic idle(input int n, input bit en, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 0, en, tag);
  endtask

  initial begin
    int sz;
    reset_n     = 1'b0;
    sense_valid = 1'b0;
    sense_size  = 6'd0;
    enable      = 1'b0;
    m_cyc       = 0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_outputs("reset");
    reset_n = 1'b1;

    // Three valid coins with enable high
    coin(21, 1, 2, 1, "basic");
    coin(17, 1, 2, 1, "basic");
    coin(24, 2, 2, 1, "basic");
    idle(2, 1'b1, "basic_idle");

    // Overflow with enable low, then drain
    for (int i = 0; i < 5; i++) coin(20 + (i % 3), 1, 1, 0, "fill");
    idle(3, 1'b0, "fill_hold");
    idle(6, 1'b1, "drain");

    // Invalid sizes, second one extends the reject window
    coin(23, 1, 5, 1, "inv23");
    coin(19, 1, 1, 1, "inv19a");
    coin(19, 1, 6, 1, "inv19b");

    // Full FIFO, coin at the same edge as a pop
    for (int i = 0; i < 4; i++) coin(18, 1, 1, 0, "full");
    coin(24, 1, 1, 1, "push_pop");
    idle(5, 1'b1, "push_pop_drain");

    // Randomized coin traffic (runs shorter than the jam threshold)
    for (int i = 0; i < 250; i++) begin
      sz = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                       : int'($urandom_range(15, 27));
      coin(sz, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 2, "rand");
    end
    idle(6, 1'b1, "rand_drain");

    // Jam: buffer coins, hold the sensor, then a valid coin is rejected
    coin(21, 1, 1, 0, "pre_jam");
    coin(25, 1, 1, 0, "pre_jam");
    coin(17, 10, 2, 0, "jam_hold");
    coin(22, 1, 4, 0, "jam_coin");
    idle(4, 1'b1, "jam_drain");

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) coin(24, 1, 1, 0, "pre_rst");
    step(1'b0, 0, 1'b1, "pre_rst_pop");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    idle(5, 1'b1, "post_rst");
    coin(20, 1, 2, 1, "post_rst_coin");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
